sram_multiport: RTL
===================

Name: sram_multiport

Overview:
Parametrised behavioural SRAM model and next-generation successor to the single-port model. Adds NUM_PORTS independent read/write ports, configurable read latency with a per-port read-valid strobe, a configurable byte-lane width, defined collision semantics and out-of-range address handling. Used as the generic memory macro stand-in for caches, scratchpads and FIFOs in simulation and FPGA flows.

Parameters:
NUM_PORTS, 2, number of independent ports; legal range 1..4.
DATA_WIDTH, 64, word width in bits.
NUM_WORDS, 1024, depth in words; power of two not required; minimum 2.
BYTE_WIDTH, 8, bits per write-enable lane; BE_WIDTH = ceil(DATA_WIDTH/BYTE_WIDTH); the last lane may be partial.
LATENCY, 1, read latency in cycles; legal range 1..4.
- Derived: AW = $clog2(NUM_WORDS).
- Illegal parameter values are elaboration errors ($fatal).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  asynchronous active-low reset.
req_i  in  NUM_PORTS  per-port request.
we_i  in  NUM_PORTS  per-port write enable; 1 = write, 0 = read; qualified by req_i.
addr_i  in  NUM_PORTS x AW  per-port word address.
wdata_i  in  NUM_PORTS x DATA_WIDTH  per-port write data.
be_i  in  NUM_PORTS x BE_WIDTH  per-port byte-lane enables.
rdata_o  out  NUM_PORTS x DATA_WIDTH  per-port read data.
rvalid_o  out  NUM_PORTS  per-port read-data-valid strobe.
collision_o  out  NUM_PORTS  per-port collision flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_ni low): entire array cleared to 0; all read pipeline stages cleared; rdata_o = 0, rvalid_o = 0, collision_o = 0. Reset asserted mid-operation discards all in-flight reads; no rvalid_o is produced for them after reset releases.
- Write (req=1, we=1): every lane i with be_i[i]=1 updates at the clock edge; lanes with be_i[i]=0 are unchanged. be_i all-zero is a legal no-op. No rvalid_o is produced.
- Read (req=1, we=0): the word is sampled at the request edge; rdata_o is presented with rvalid_o=1 exactly LATENCY cycles after the request cycle (LATENCY=1: valid in the cycle after the request). Fully pipelined: one read per port per cycle, back-to-back reads yield back-to-back valids.
- rdata_o holds its last valid value whenever rvalid_o=0; it never changes without rvalid_o.
- Read-during-write, different ports, same address, same cycle: read-first; the read returns the pre-write contents.
- Write-write, same address, same cycle: resolved per lane; the lowest-index port with that lane enabled wins. Lanes enabled by only one port are written normally.
- Out-of-range address (addr_i >= NUM_WORDS, non-power-of-two depth only): write dropped; read returns 0 with normal rvalid_o timing.
- Ports are fully independent; there is no back-pressure and no stall.

Optional Feature:
Macro: SRAM_MULTIPORT_COLLISION_CHECK_EN.
- Defined: collision_o[p] is asserted in the cycle after port p's request when, in the request cycle, port p and at least one other port both had req=1 on the same address and at least one of them had we=1. The flag is a 1-cycle pulse, independent of LATENCY. In simulation, each collision is also reported with $warning (time, ports, address).
- Not defined: collision_o is tied to 0 and there is no collision logic.
- Read/write data behaviour is identical in both builds.

Test Plan:
- Reset then read: release reset, port0 reads addr 5 -> with LATENCY=1, rdata_o[0]=0 and rvalid_o[0]=1 one cycle later; rvalid_o=0 in all other cycles.
- Byte-enable write: port0 writes 0xFFFF_FFFF_FFFF_FFFF to addr 3, then writes 0x1122_3344_5566_7788 with be=0x0F; read addr 3 -> 0xFFFF_FFFF_5566_7788.
- Latency pipeline: LATENCY=3; port1 reads addrs 0,1,2 in consecutive cycles after writing 0xA0,0xA1,0xA2 -> rvalid_o[1] high for 3 consecutive cycles starting 3 cycles after the first read; data 0xA0,0xA1,0xA2 in order.
- Read-first collision: addr 7 holds 0x11; in one cycle port0 writes 0x22 (be all-ones) and port1 reads addr 7 -> port1 gets 0x11; a later read returns 0x22; collision_o = 2'b11 one cycle later when the macro is defined, 2'b00 when it is not.
- Write-write per lane: port0 writes 0xAAAA with be=0b01 and port1 writes 0xBBBB with be=0b11 (DATA_WIDTH=16) to the same addr -> the word reads back 0xBBAA.
- Out of range / reset mid-read: NUM_WORDS=6, write addr 7 then read addr 7 -> 0 with rvalid; LATENCY=2, read issued, rst_ni pulsed low before data returns -> no rvalid_o after reset releases, array reads back 0.

Source files
------------

// File: rtl/sram_multiport_if.sv
// Request/response bundle for sram_multiport; one lane per port in every packed vector.
interface sram_multiport_if #(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned AW         = 10,
   parameter int unsigned BE_WIDTH   = 8
);
   logic [NUM_PORTS-1:0]                 req_i;
   logic [NUM_PORTS-1:0]                 we_i;
   logic [NUM_PORTS-1:0][AW-1:0]         addr_i;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
   logic [NUM_PORTS-1:0][BE_WIDTH-1:0]   be_i;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o;
   logic [NUM_PORTS-1:0]                 rvalid_o;
   logic [NUM_PORTS-1:0]                 collision_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i,
      input  rdata_o, rvalid_o, collision_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i,
      output rdata_o, rvalid_o, collision_o
   );
endinterface

// File: rtl/sram_multiport.sv
// Multi-port behavioural SRAM: per-lane writes, read-first, fixed-latency pipelined reads.
// Optional collision flags and warnings: define SRAM_MULTIPORT_COLLISION_CHECK_EN.
module sram_multiport #(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_WORDS  = 1024,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned LATENCY    = 1
) (
   input logic             clk_i,
   input logic             rst_ni,
   sram_multiport_if.slave bus
);
   localparam int unsigned AW = $clog2(NUM_WORDS);

   if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : g_err_ports
      $fatal(1, "sram_multiport: NUM_PORTS must be 1..4");
   end
   if (LATENCY < 1 || LATENCY > 4) begin : g_err_lat
      $fatal(1, "sram_multiport: LATENCY must be 1..4");
   end
   if (NUM_WORDS < 2) begin : g_err_words
      $fatal(1, "sram_multiport: NUM_WORDS must be >= 2");
   end
   if (DATA_WIDTH < 1 || BYTE_WIDTH < 1) begin : g_err_width
      $fatal(1, "sram_multiport: DATA_WIDTH and BYTE_WIDTH must be >= 1");
   end

   logic [DATA_WIDTH-1:0] r_mem       [NUM_WORDS];
   logic [DATA_WIDTH-1:0] r_pipe_data [LATENCY][NUM_PORTS];
   logic [NUM_PORTS-1:0]  r_pipe_vld  [LATENCY];
   logic [NUM_PORTS-1:0]  w_in_range;
   logic [NUM_PORTS-1:0]  w_wr;
   logic [NUM_PORTS-1:0]  w_rd;

   always_comb begin
      w_in_range = '0;
      w_wr       = '0;
      w_rd       = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_in_range[p] = 32'(bus.addr_i[p]) < NUM_WORDS;
         w_wr[p]       = bus.req_i[p] & bus.we_i[p] & w_in_range[p];
         w_rd[p]       = bus.req_i[p] & ~bus.we_i[p];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int w = 0; w < NUM_WORDS; w++) r_mem[w] <= '0;
      end else begin
         // Highest port first: the lowest-index port's assignment is scheduled last and wins per lane.
         for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (w_wr[p]) begin
               for (int b = 0; b < DATA_WIDTH; b++) begin
                  if (bus.be_i[p][b / BYTE_WIDTH]) r_mem[bus.addr_i[p]][b] <= bus.wdata_i[p][b];
               end
            end
         end
      end
   end

   // Data stages only load behind a valid, so the last stage holds its value between valids.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < LATENCY; s++) begin
            r_pipe_vld[s] <= '0;
            for (int p = 0; p < NUM_PORTS; p++) r_pipe_data[s][p] <= '0;
         end
      end else begin
         r_pipe_vld[0] <= w_rd;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_rd[p]) r_pipe_data[0][p] <= w_in_range[p] ? r_mem[bus.addr_i[p]] : '0;
         end
         for (int s = 1; s < LATENCY; s++) begin
            r_pipe_vld[s] <= r_pipe_vld[s-1];
            for (int p = 0; p < NUM_PORTS; p++) begin
               if (r_pipe_vld[s-1][p]) r_pipe_data[s][p] <= r_pipe_data[s-1][p];
            end
         end
      end
   end

   always_comb begin
      bus.rvalid_o = r_pipe_vld[LATENCY-1];
      for (int p = 0; p < NUM_PORTS; p++) bus.rdata_o[p] = r_pipe_data[LATENCY-1][p];
   end

`ifdef SRAM_MULTIPORT_COLLISION_CHECK_EN
   logic [NUM_PORTS-1:0] w_coll;
   logic [NUM_PORTS-1:0] r_coll;

   always_comb begin
      w_coll = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int q = 0; q < NUM_PORTS; q++) begin
            if (p != q && bus.req_i[p] && bus.req_i[q] && bus.addr_i[p] == bus.addr_i[q] &&
                (bus.we_i[p] || bus.we_i[q])) begin
               w_coll[p] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_coll <= '0;
      else         r_coll <= w_coll;
   end

   assign bus.collision_o = r_coll;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = p + 1; q < NUM_PORTS; q++) begin
               if (bus.req_i[p] && bus.req_i[q] && bus.addr_i[p] == bus.addr_i[q] &&
                   (bus.we_i[p] || bus.we_i[q])) begin
                  $warning("%0t: sram_multiport collision ports %0d/%0d addr 0x%0h",
                           $time, p, q, bus.addr_i[p]);
               end
            end
         end
      end
   end
`endif
`else
   assign bus.collision_o = '0;
`endif
endmodule
